dmem_responder: RTL and testbench

- Memory-side responder for the core's data port: 64-word x 32-bit store with four byte lanes.
- Accepts one read or byte-strobed write per request over a valid/ready handshake.
- Inserts a programmable number of wait states, then returns a response over a valid/ready handshake.
- Sits between the core's load/store path (byte address, 32-bit write data, 4-bit lane write enables) and the data storage. Replaces direct instantiation of per-lane memories.

---
 rtl/dmem_responder.sv | 191 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data port.
// A 2**DEPTH_LOG2 x 32-bit store with four byte lanes. It accepts one read or
// byte-strobed write per valid/ready request, waits WAIT_STATES extra cycles,
// then holds a response until the requester takes it.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   req_valid   request present
//   req_ready   responder can accept a request this cycle
//   req_addr    byte address (word index = req_addr[DEPTH_LOG2+1:2])
//   req_wdata   write data, lane i = bits [8i+7:8i]
//   req_wstrb   lane write enables, 4'b0000 = read
//   resp_valid  response present
//   resp_ready  requester accepts the response
//   resp_rdata  response data (merged post-write word for writes)
//   resp_err    request was misaligned (no access performed)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request in flight, ready for a new one
// WAIT  | request latched, counting down wait states
// RESP  | access committed, response held until resp_ready

module dmem_responder #(
    parameter int WAIT_STATES = 0,
    parameter int DEPTH_LOG2  = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic accept;
    logic commit;

    logic [7:0]  lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;

    logic [7:0]  c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_wstrb;
    logic [DEPTH_LOG2-1:0] c_idx;
    logic        c_aligned;
    logic [31:0] old_word;
    logic [31:0] new_word;

    logic [31:0] mem [2**DEPTH_LOG2];

    // RESP can hand over to the next request on the same edge the response
    // is taken, which is what allows one response per cycle at zero waits.
    assign req_ready  = (state == IDLE) || ((state == RESP) && resp_ready);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    if (accept) begin
                        if (WAIT_STATES == 0) begin
                            state_nxt = RESP;
                            commit    = 1'b1;
                        end else begin
                            state_nxt = WAIT;
                            cnt_nxt   = WAIT_LOAD;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr  <= 8'd0;
            lat_wdata <= 32'd0;
            lat_wstrb <= 4'd0;
        end else if (accept) begin
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
        end
    end

    // A commit from WAIT uses the latched request; a zero-wait commit happens
    // on the accept edge itself, so the live request is used directly.
    always_comb begin
        if (state == WAIT) begin
            c_addr  = lat_addr;
            c_wdata = lat_wdata;
            c_wstrb = lat_wstrb;
        end else begin
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_wstrb = req_wstrb;
        end
    end

    assign c_idx     = c_addr[DEPTH_LOG2+1:2];
    assign c_aligned = (c_addr[1:0] == 2'b00);
    assign old_word  = mem[c_idx];

    always_comb begin
        new_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (c_wstrb[i]) begin
                new_word[8*i +: 8] = c_wdata[8*i +: 8];
            end
        end
    end

    // Storage has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (commit && c_aligned) begin
            for (int i = 0; i < 4; i++) begin
                if (c_wstrb[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (commit) begin
            resp_rdata <= c_aligned ? new_word : 32'd0;
            resp_err   <= ~c_aligned;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        rv0 = 1'b0, rr0, pv0, pr0 = 1'b0, re0;
    logic [7:0]  ra0 = 8'd0;
    logic [31:0] wd0 = 32'd0, rd0;
    logic [3:0]  ws0 = 4'd0;

    logic        rv3 = 1'b0, rr3, pv3, pr3 = 1'b0, re3;
    logic [7:0]  ra3 = 8'd0;
    logic [31:0] wd3 = 32'd0, rd3;
    logic [3:0]  ws3 = 4'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_STATES(0), .DEPTH_LOG2(6)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(rv0), .req_ready(rr0), .req_addr(ra0),
        .req_wdata(wd0), .req_wstrb(ws0),
        .resp_valid(pv0), .resp_ready(pr0), .resp_rdata(rd0), .resp_err(re0)
    );

    dmem_responder #(.WAIT_STATES(3), .DEPTH_LOG2(6)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(rv3), .req_ready(rr3), .req_addr(ra3),
        .req_wdata(wd3), .req_wstrb(ws3),
        .resp_valid(pv3), .resp_ready(pr3), .resp_rdata(rd3), .resp_err(re3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] held;

    initial begin
        // reset: three cycles high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_valid0", 32'(pv0), 32'd0);
            chk("rst_rdata0", rd0, 32'd0);
            chk("rst_err0", 32'(re0), 32'd0);
        end
        chk("rst_valid3", 32'(pv3), 32'd0);
        rst = 1'b0;
        tick();
        chk("rel_ready0", 32'(rr0), 32'd1);
        chk("rel_ready3", 32'(rr3), 32'd1);

        // zero-wait word write then back-to-back read
        rv0 = 1'b1; ra0 = 8'h10; wd0 = 32'hDEADBEEF; ws0 = 4'hF; pr0 = 1'b0;
        tick();
        chk("wr_valid", 32'(pv0), 32'd1);
        chk("wr_rdata", rd0, 32'hDEADBEEF);
        chk("wr_err", 32'(re0), 32'd0);
        chk("stall_ready0", 32'(rr0), 32'd0);
        ws0 = 4'h0; wd0 = 32'd0; pr0 = 1'b1;
        #1;
        chk("b2b_ready", 32'(rr0), 32'd1);
        tick();
        chk("rd_valid", 32'(pv0), 32'd1);
        chk("rd_rdata", rd0, 32'hDEADBEEF);
        chk("rd_err", 32'(re0), 32'd0);
        rv0 = 1'b0;
        tick();
        chk("idle_valid0", 32'(pv0), 32'd0);

        // byte lane 2 write
        rv0 = 1'b1; ra0 = 8'h10; wd0 = 32'h00AA0000; ws0 = 4'b0100; pr0 = 1'b0;
        tick();
        chk("lane_wr_rdata", rd0, 32'hDEAABEEF);
        ws0 = 4'h0; wd0 = 32'd0; pr0 = 1'b1;
        tick();
        chk("lane_rd_rdata", rd0, 32'hDEAABEEF);
        rv0 = 1'b0;
        tick();

        // misaligned write is rejected and leaves storage untouched
        rv0 = 1'b1; ra0 = 8'h11; wd0 = 32'h12345678; ws0 = 4'hF; pr0 = 1'b1;
        tick();
        chk("mis_valid", 32'(pv0), 32'd1);
        chk("mis_err", 32'(re0), 32'd1);
        chk("mis_rdata", rd0, 32'd0);
        ra0 = 8'h10; ws0 = 4'h0; wd0 = 32'd0;
        tick();
        chk("mis_rd_err", 32'(re0), 32'd0);
        chk("mis_rd_rdata", rd0, 32'hDEAABEEF);
        rv0 = 1'b0;
        tick();

        // three wait states: write 0x10
        rv3 = 1'b1; ra3 = 8'h10; wd3 = 32'h11223344; ws3 = 4'hF; pr3 = 1'b0;
        tick();
        rv3 = 1'b0;
        chk("ws_n0", 32'(pv3), 32'd0);
        tick();
        chk("ws_n1", 32'(pv3), 32'd0);
        tick();
        chk("ws_n2", 32'(pv3), 32'd0);
        tick();
        chk("ws_n3", 32'(pv3), 32'd1);
        chk("ws_wr_rdata", rd3, 32'h11223344);
        pr3 = 1'b1;
        tick();
        chk("ws_idle", 32'(pv3), 32'd0);
        pr3 = 1'b0;

        // read with backpressure
        rv3 = 1'b1; ra3 = 8'h10; ws3 = 4'h0; wd3 = 32'd0;
        tick();
        rv3 = 1'b0;
        tick();
        tick();
        chk("bp_n2", 32'(pv3), 32'd0);
        tick();
        chk("bp_n3", 32'(pv3), 32'd1);
        held = rd3;
        chk("bp_rdata", rd3, 32'h11223344);
        rv3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(pv3), 32'd1);
            chk("bp_stable", rd3, 32'h11223344);
            chk("bp_ready", 32'(rr3), 32'd0);
        end
        rv3 = 1'b0;
        pr3 = 1'b1;
        #1;
        chk("bp_release_ready", 32'(rr3), 32'd1);
        tick();
        chk("bp_idle_valid", 32'(pv3), 32'd0);
        chk("bp_idle_ready", 32'(rr3), 32'd1);
        pr3 = 1'b0;

        // seed 0x20, then abort a write to it with reset in WAIT
        rv3 = 1'b1; ra3 = 8'h20; wd3 = 32'h55555555; ws3 = 4'hF;
        tick();
        rv3 = 1'b0;
        tick(); tick(); tick();
        chk("seed_valid", 32'(pv3), 32'd1);
        pr3 = 1'b1;
        tick();
        pr3 = 1'b0;
        rv3 = 1'b1; ra3 = 8'h20; wd3 = 32'hCAFEF00D; ws3 = 4'hF;
        tick();
        rv3 = 1'b0;
        rst = 1'b1;
        #1;
        chk("wrst_valid", 32'(pv3), 32'd0);
        chk("wrst_rdata", rd3, 32'd0);
        tick();
        rst = 1'b0;
        rv3 = 1'b1; ra3 = 8'h20; wd3 = 32'd0; ws3 = 4'h0;
        tick();
        rv3 = 1'b0;
        tick(); tick(); tick();
        chk("wrst_rd_valid", 32'(pv3), 32'd1);
        chk("wrst_rd_rdata", rd3, 32'h55555555);
        pr3 = 1'b1;
        tick();
        pr3 = 1'b0;

        // zero-wait streaming: one response per cycle
        rv0 = 1'b1; ra0 = 8'h40; wd0 = 32'hA0000000; ws0 = 4'hF; pr0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_valid", 32'(pv0), 32'd1);
            chk("stream_rdata", rd0, 32'hA0000000 + 32'(i));
            if (i < 3) begin
                ra0 = 8'(8'h44 + 4 * i);
                wd0 = 32'hA0000000 + 32'(i + 1);
            end else begin
                rv0 = 1'b0;
            end
        end
        tick();
        chk("stream_end", 32'(pv0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
